// File: rtl/nios_system_sysid_checker.sv
// Avalon-MM master that reads the sysid slave (ID at word 0, timestamp at word 1)
// after reset or on request and flags whether both match the build-time values.
module nios_system_sysid_checker #(
  parameter int              DATA_W         = 32,
  parameter logic [DATA_W-1:0] EXPECTED_ID  = 32'h8888_8888,
  parameter logic [DATA_W-1:0] EXPECTED_TS  = 32'h5845_27F9,
  parameter int              TIMEOUT_CYCLES = 255,
  parameter bit              AUTO_START     = 1'b1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              ts_ok,
  output logic              timeout,
  output logic [DATA_W-1:0] id_value,
  output logic [DATA_W-1:0] ts_value
);

  localparam logic [7:0] TO_LOAD = TIMEOUT_CYCLES[7:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RD_ID = 2'd1,
    RD_TS = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t     state, state_nxt;
  logic [7:0] cnt, cnt_nxt;
  logic       auto_pend;
  logic       clr_flags, id_cap, ts_cap, to_set;

  function automatic logic word_match(input logic [DATA_W-1:0] got,
                                      input logic [DATA_W-1:0] exp);
    return got == exp;
  endfunction

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    clr_flags = 1'b0;
    id_cap    = 1'b0;
    ts_cap    = 1'b0;
    to_set    = 1'b0;
    case (state)
      IDLE: begin
        if (start || auto_pend) begin
          state_nxt = RD_ID;
          cnt_nxt   = TO_LOAD;
          clr_flags = 1'b1;
        end
      end
      RD_ID: begin
        if (!avm_waitrequest) begin
          id_cap    = 1'b1;
          cnt_nxt   = TO_LOAD;
          state_nxt = RD_TS;
        end else if (cnt == 8'd0) begin
          to_set    = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      RD_TS: begin
        if (!avm_waitrequest) begin
          ts_cap    = 1'b1;
          state_nxt = DONE;
        end else if (cnt == 8'd0) begin
          to_set    = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt - 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= TO_LOAD;
      auto_pend   <= AUTO_START;
      avm_read    <= 1'b0;
      avm_address <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      id_ok       <= 1'b0;
      ts_ok       <= 1'b0;
      timeout     <= 1'b0;
      id_value    <= '0;
      ts_value    <= '0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      auto_pend   <= 1'b0;
      avm_read    <= (state_nxt == RD_ID) || (state_nxt == RD_TS);
      avm_address <= (state_nxt == RD_TS);
      busy        <= (state_nxt != IDLE);
      done        <= (state_nxt == DONE);
      if (clr_flags) begin
        id_ok   <= 1'b0;
        ts_ok   <= 1'b0;
        timeout <= 1'b0;
      end
      if (id_cap) begin
        id_value <= avm_readdata;
        id_ok    <= word_match(avm_readdata, EXPECTED_ID);
      end
      if (ts_cap) begin
        ts_value <= avm_readdata;
        ts_ok    <= word_match(avm_readdata, EXPECTED_TS);
      end
      if (to_set) timeout <= 1'b1;
    end
  end

endmodule

// File: tb/tb_nios_system_sysid_checker.sv
// Randomized bench for nios_system_sysid_checker with a transaction-level slave/reference model.
module tb_nios_system_sysid_checker;

  localparam int          T   = 255;
  localparam logic [31:0] EID = 32'h8888_8888;
  localparam logic [31:0] ETS = 32'h5845_27F9;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        avm_address, avm_read;
  logic        avm_waitrequest = 1'b0;
  logic [31:0] avm_readdata = '0;
  logic        busy, done, id_ok, ts_ok, timeout;
  logic [31:0] id_value, ts_value;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_id = '0;
  logic [31:0] m_ts = '0;

  nios_system_sysid_checker dut (
    .clock(clock), .reset(reset), .start(start),
    .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .busy(busy), .done(done), .id_ok(id_ok), .ts_ok(ts_ok), .timeout(timeout),
    .id_value(id_value), .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=expired exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_read"}, avm_read, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

  // One full check: the slave stalls wid/wts cycles on each read (more than T means it never answers).
  // Called just after a negedge; the check begins at the next posedge (start or auto-start).
  task automatic run_check(input bit use_start, input int wid, input int wts,
                           input logic [31:0] did, input logic [31:0] dts,
                           input int start_id_cyc, input bit start_on_done);
    int          w, len;
    bit          to;
    bit          exp_id_ok, exp_ts_ok;
    logic [31:0] dat;
    start = use_start;
    avm_waitrequest = 1'b0;
    step();
    to = 0; exp_id_ok = 0; exp_ts_ok = 0;
    for (int ph = 0; ph < 2 && !to; ph++) begin
      w   = (ph == 0) ? wid : wts;
      dat = (ph == 0) ? did : dts;
      to  = (w > T);
      len = to ? T + 1 : w + 1;
      for (int c = 0; c < len; c++) begin
        check_eq("rd_strobe", avm_read, 1);
        check_eq("rd_addr", avm_address, ph);
        check_eq("rd_busy", busy, 1);
        check_eq("rd_done", done, 0);
        check_eq("rd_id_ok", id_ok, exp_id_ok);
        check_eq("rd_ts_ok", ts_ok, 0);
        check_eq("rd_timeout", timeout, 0);
        start = (ph == 0 && c == start_id_cyc);
        avm_waitrequest = (c < w);
        avm_readdata = (c < w) ? $urandom : dat;
        step();
      end
      if (!to) begin
        if (ph == 0) begin m_id = did; exp_id_ok = (did == EID); end
        else         begin m_ts = dts; exp_ts_ok = (dts == ETS); end
      end
    end
    avm_waitrequest = 1'b0;
    avm_readdata = $urandom;
    check_eq("end_done", done, 1);
    check_eq("end_busy", busy, 1);
    check_eq("end_read", avm_read, 0);
    check_eq("end_id_ok", id_ok, exp_id_ok);
    check_eq("end_ts_ok", ts_ok, exp_ts_ok);
    check_eq("end_timeout", timeout, to);
    check_eq("end_id_value", id_value, m_id);
    check_eq("end_ts_value", ts_value, m_ts);
    start = start_on_done;
    step();
    start = 1'b0;
    check_idle("post");
    check_eq("hold_id_value", id_value, m_id);
    check_eq("hold_ts_value", ts_value, m_ts);
    check_eq("hold_id_ok", id_ok, exp_id_ok);
  endtask

  task automatic check_reset_values(input string tag);
    check_idle(tag);
    check_eq({tag, "_addr"}, avm_address, 0);
    check_eq({tag, "_id_ok"}, id_ok, 0);
    check_eq({tag, "_ts_ok"}, ts_ok, 0);
    check_eq({tag, "_timeout"}, timeout, 0);
    check_eq({tag, "_id_value"}, id_value, 0);
    check_eq({tag, "_ts_value"}, ts_value, 0);
  endtask

  initial begin
    int          wid, wts, gap, sic;
    logic [31:0] did, dts;

    reset = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_reset_values("rst");
    reset = 1'b0;
    run_check(0, 0, 0, EID, ETS, -1, 0);

    run_check(1, 0, 0, EID, 32'h1234_5678, -1, 0);
    run_check(1, 3, 3, EID, ETS, -1, 0);
    run_check(1, 0, T + 1, EID, ETS, -1, 0);
    run_check(1, T + 1, 0, EID, ETS, -1, 0);
    run_check(1, T, T, EID, ETS, -1, 0);
    run_check(1, 2, 1, 32'h8888_8889, ETS, 1, 1);
    check_idle("drop_idle");
    run_check(1, 0, 0, EID, ETS, 0, 1);

    // Reset in the middle of a stalled timestamp read, then auto-start reruns.
    start = 1'b1;
    step();
    start = 1'b0;
    check_eq("mid_rd_id", avm_read, 1);
    avm_readdata = EID;
    avm_waitrequest = 1'b0;
    step();
    check_eq("mid_rd_ts_addr", avm_address, 1);
    avm_waitrequest = 1'b1;
    repeat (3) step();
    check_eq("mid_stall_read", avm_read, 1);
    check_eq("mid_stall_addr", avm_address, 1);
    reset = 1'b1;
    step();
    check_reset_values("mid_rst");
    reset = 1'b0;
    avm_waitrequest = 1'b0;
    m_id = '0;
    m_ts = '0;
    run_check(0, 1, 0, EID, ETS, -1, 0);

    repeat (25) begin
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        check_idle("gap");
        step();
      end
      wid = ($urandom_range(0, 11) == 0) ? T + 1 : $urandom_range(0, 4);
      wts = ($urandom_range(0, 11) == 0) ? T + 1 : $urandom_range(0, 4);
      did = $urandom_range(0, 1) ? EID : $urandom;
      dts = $urandom_range(0, 1) ? ETS : $urandom;
      sic = $urandom_range(0, 3) - 1;
      run_check(1, wid, wts, did, dts, sic, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
